// File: rtl/if_fetch_pkg.sv
// Fetch controller state encoding, reset address default and PC helpers.
package if_fetch_pkg;

  localparam logic [31:0] IF_RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  // Instruction addresses are always word aligned; low bits of any target are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] i_addr);
    return i_addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_stage_pkg.sv
// Shared fetch-to-decode packet type for the IF stage.
package if_stage_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } if_stage_out_t;

endpackage

// File: rtl/if_pc_gen.sv
// Combinational next-fetch-PC selection: redirect > prediction > sequential.
// Prediction is only honoured when IF_FETCH_PREDICT_EN is defined.
module if_pc_gen
  import if_fetch_pkg::*;
(
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_predict_taken,
  input  logic [31:0] i_predict_pc,
  input  logic [31:0] i_inflight_pc,
  output logic [31:0] o_seq_pc,
  output logic [31:0] o_next_pc
);

  logic [31:0] w_pred_pc;

  assign o_seq_pc = i_inflight_pc + 32'd4;

`ifdef IF_FETCH_PREDICT_EN
  assign w_pred_pc = i_predict_taken ? word_align(i_predict_pc) : o_seq_pc;
`else
  logic w_unused_predict;
  assign w_unused_predict = ^{i_predict_taken, i_predict_pc};
  assign w_pred_pc        = o_seq_pc;
`endif

  assign o_next_pc = i_redirect ? word_align(i_redirect_pc) : w_pred_pc;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, one-entry stall buffer,
// redirect kill handling. Optional branch prediction via IF_FETCH_PREDICT_EN.
module if_fetch_ctrl
  import if_fetch_pkg::*;
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        predict_taken,
  input  logic [31:0] predict_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] pc4
);

  fetch_state_e  r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_inflight_pc;
  logic          r_kill;
  if_stage_out_t r_buf;
  if_stage_out_t r_out;

  logic [31:0]   w_seq_pc;
  logic [31:0]   w_next_pc;
  logic          w_accept;
  logic          w_kill_on_redirect;

  if_pc_gen u_pc_gen (
    .i_redirect      (redirect),
    .i_redirect_pc   (redirect_pc),
    .i_predict_taken (predict_taken),
    .i_predict_pc    (predict_pc),
    .i_inflight_pc   (r_inflight_pc),
    .o_seq_pc        (w_seq_pc),
    .o_next_pc       (w_next_pc)
  );

  assign w_accept = (r_state == WAIT) && imem_rvalid && !r_kill;

  // A redirect only has to poison a response that is still on its way back.
  assign w_kill_on_redirect = ((r_state == WAIT) && !imem_rvalid) ||
                              ((r_state == REQ)  && imem_gnt);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state       <= IDLE;
      r_fetch_pc    <= RESET_PC;
      r_inflight_pc <= RESET_PC;
      r_kill        <= 1'b0;
      r_buf         <= '0;
      r_out         <= '0;
    end else if (redirect) begin
      r_fetch_pc  <= w_next_pc;
      r_out.valid <= 1'b0;
      r_buf.valid <= 1'b0;
      if (w_kill_on_redirect) begin
        r_kill  <= 1'b1;
        r_state <= WAIT;
      end else begin
        r_kill  <= 1'b0;
        r_state <= REQ;
      end
    end else begin
      case (r_state)
        IDLE: r_state <= REQ;
        REQ: begin
          if (imem_gnt) begin
            r_inflight_pc <= r_fetch_pc;
            r_state       <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (r_kill) begin
              r_kill  <= 1'b0;
              r_state <= REQ;
            end else begin
              r_fetch_pc <= w_next_pc;
              if (stall) begin
                r_buf   <= '{valid: 1'b1, inst: imem_rdata,
                             pc: r_inflight_pc, pc4: w_seq_pc};
                r_state <= HOLD;
              end else begin
                r_state <= REQ;
              end
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            r_buf.valid <= 1'b0;
            r_state     <= REQ;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Decode-facing packet only moves when decode is not stalling.
      if (!stall) begin
        if (w_accept) begin
          r_out <= '{valid: 1'b1, inst: imem_rdata,
                     pc: r_inflight_pc, pc4: w_seq_pc};
        end else if ((r_state == HOLD) && r_buf.valid) begin
          r_out <= r_buf;
        end else begin
          r_out.valid <= 1'b0;
        end
      end
    end
  end

  assign imem_req   = (r_state == REQ);
  assign imem_addr  = r_fetch_pc;
  assign inst_valid = r_out.valid;
  assign inst       = r_out.inst;
  assign pc         = r_out.pc;
  assign pc4        = r_out.pc4;

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 arst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 stall  in  1  SHALL mean the decode stage cannot accept; output registers hold.
REQ-005 redirect  in  1  SHALL mean a branch/jump misprediction; the fetch stream restarts at redirect_pc.
REQ-006 redirect_pc  in  32  SHALL be the corrected target; bits [1:0] are ignored and treated as 2'b00.
REQ-007 predict_taken, predict_pc  in  1/32  SHALL be the predictor's verdict and target for the instruction returning this cycle.
REQ-008 imem_req, imem_addr  out  1/32  SHALL be the instruction-memory request and its word-aligned address.
REQ-009 imem_gnt  in  1  SHALL mean the request is accepted in this cycle.
REQ-010 imem_rvalid, imem_rdata  in  1/32  SHALL be the read response and its data.
REQ-011 inst_valid, inst, pc, pc4  out  1/32/32/32  SHALL be the registered fetch packet delivered to decode.

Function
REQ-012 States SHALL be IDLE, REQ, WAIT and HOLD, with at most one outstanding memory request.
REQ-013 IDLE SHALL go to REQ on the first clock edge after arst_n deasserts.
REQ-014 In REQ, imem_req=1 and imem_addr=fetch_pc; on imem_gnt, fetch_pc is latched as inflight_pc and the state goes to WAIT.
REQ-015 imem_addr SHALL stay stable while imem_req=1 without imem_gnt, except in a redirect cycle.
REQ-016 In WAIT, imem_rvalid with !stall SHALL load inst/pc/pc4 (pc4=inflight_pc+4), set inst_valid=1 next cycle, and go to REQ.
REQ-017 imem_rvalid with stall SHALL capture the response into a one-entry buffer and go to HOLD.
REQ-018 HOLD SHALL present the buffered packet once !stall and then go to REQ; no request is issued in HOLD.
REQ-019 With stall=1, inst_valid, inst, pc and pc4 SHALL hold their values.
REQ-020 With stall=0 and no new packet, inst_valid SHALL drop to 0.
REQ-021 Next fetch_pc SHALL be inflight_pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-022 Redirect SHALL have priority over stall and prediction.
REQ-023 On redirect: fetch_pc<=redirect_pc, inst_valid<=0, and the HOLD buffer is cleared; the state goes to REQ, except as in REQ-024.
REQ-024 A redirect in WAIT, or in REQ coincident with imem_gnt, SHALL set kill and enter WAIT.
REQ-025 A response arriving while kill=1 SHALL be discarded; kill is cleared and the state goes to REQ.
REQ-026 A redirect coincident with imem_rvalid SHALL discard that response.
REQ-027 Minimum latency SHALL be: gnt in cycle N, rvalid in N+1, inst_valid in N+2.

Reset
REQ-028 On arst_n=0: state=IDLE, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, pc=0, pc4=0, buffer empty, kill=0.
REQ-029 Reset asserted mid-transaction SHALL abandon the outstanding request; a stale imem_rvalid after reset is ignored because the state is not WAIT.

Configuration
REQ-030 With IF_FETCH_PREDICT_EN defined, an accepted response with predict_taken=1 SHALL set next fetch_pc=predict_pc (bits [1:0] forced 0) instead of inflight_pc+4.
REQ-031 Without IF_FETCH_PREDICT_EN, predict_taken and predict_pc SHALL be ignored and fetch is strictly sequential plus redirects.

Structure
REQ-032 Package if_fetch_pkg SHALL hold the fetch_state_e enum (IDLE, REQ, WAIT, HOLD) and the RESET_PC default constant.
REQ-033 The output packet fields SHALL match the inst/pc/pc4 fields of if_stage_out_t in if_stage_pkg.
REQ-034 The next-PC selection (sequential, predicted, redirect) SHALL be a combinational sub-module if_pc_gen.

Verification
REQ-035 Reset with RESET_PC=0x100 and gnt tied to 1 with rvalid one cycle later -> imem_addr sequence 0x100, 0x104, 0x108 and inst_valid from cycle 3.
REQ-036 stall=1 for 3 cycles while a response returns -> state HOLD, no imem_req, packet pc=0x104 held, delivered exactly once after release.
REQ-037 redirect to 0x200 while in WAIT -> the following rvalid data never appears on inst; next imem_addr=0x200.
REQ-038 gnt delayed 4 cycles -> imem_req and imem_addr stay stable for all 4 cycles.
REQ-039 With IF_FETCH_PREDICT_EN, predict_taken=1 and predict_pc=0x40 at rvalid -> next imem_addr=0x40; without the macro -> next imem_addr=pc+4.
REQ-040 Fetch at 0xFFFF_FFFC -> next imem_addr=0x0000_0000 and pc4=0x0000_0000.
